// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the rest of the datapath.
// The control unit is the master: it consumes the opcode and memory handshake
// and drives every strobe, the ALU class, the sticky flags and the debug state.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 2
);
  logic [6:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               alu_src;
  logic               reg_write;
  logic               branch;
  logic               jump;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal;
  logic               timeout;
  logic [2:0]         state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
           reg_write, branch, jump, alu_op, illegal, timeout, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
           reg_write, branch, jump, alu_op, illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control unit: FETCH/DECODE/EXECUTE/MEM/WB FSM with a
// bounded memory wait counter and an absorbing TRAP state that records either
// an undecodable opcode or a memory timeout until the next reset.
module multicycle_control_unit #(
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic                       clk,
  input logic                       reset_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL
  } opClass_e;

  function automatic opClass_e decodeClass(input logic [6:0] op);
    case (op)
      7'b0110011: decodeClass = CLS_R;
      7'b0010011: decodeClass = CLS_IALU;
      7'b0000011: decodeClass = CLS_LOAD;
      7'b0100011: decodeClass = CLS_STORE;
      7'b1100011: decodeClass = CLS_BRANCH;
      7'b1101111: decodeClass = CLS_JAL;
      default:    decodeClass = CLS_ILLEGAL;
    endcase
  endfunction

  state_e             stateCur;
  state_e             stateNext;
  logic [6:0]         opReg;
  logic [CNT_W-1:0]   waitCnt;
  logic               illegalFlag;
  logic               timeoutFlag;
  logic               illegalSet;
  logic               timeoutSet;
  logic               waiting;
  logic               waitExpired;
  opClass_e           liveClass;
  opClass_e           execClass;

  logic               pcWrite;
  logic               irWrite;
  logic               memRead;
  logic               memWrite;
  logic               memToReg;
  logic               aluSrc;
  logic               regWrite;
  logic               branchOut;
  logic               jumpOut;
  logic [ALUOP_W-1:0] aluOp;

  // DECODE classifies the live opcode; later states only see the latched copy.
  assign liveClass = decodeClass(bus.opcode);
  assign execClass = decodeClass(opReg);

  // A wait cycle is one spent in FETCH or MEM without a memory response; the
  // wait that would bring the counter up to TIMEOUT is the one that traps.
  assign waiting     = ((stateCur == FETCH) || (stateCur == MEM)) && !bus.mem_ready;
  assign waitExpired = (waitCnt == CNT_W'(TIMEOUT - 1));

  // State register, latched opcode, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateCur    <= FETCH;
      opReg       <= '0;
      waitCnt     <= '0;
      illegalFlag <= 1'b0;
      timeoutFlag <= 1'b0;
    end else begin
      stateCur <= stateNext;
      if (stateCur == DECODE) opReg <= bus.opcode;
      if (stateNext != stateCur) waitCnt <= '0;
      else if (waiting)          waitCnt <= waitCnt + CNT_W'(1);
      if (illegalSet) illegalFlag <= 1'b1;
      if (timeoutSet) timeoutFlag <= 1'b1;
    end
  end

  // Next-state selection and trap-cause detection.
  always_comb begin
    stateNext  = FETCH;
    illegalSet = 1'b0;
    timeoutSet = 1'b0;
    case (stateCur)
      FETCH: begin
        if (bus.mem_ready)     stateNext = DECODE;
        else if (waitExpired) begin
          stateNext  = TRAP;
          timeoutSet = 1'b1;
        end else               stateNext = FETCH;
      end
      DECODE: begin
        if (liveClass == CLS_ILLEGAL) begin
          stateNext  = TRAP;
          illegalSet = 1'b1;
        end else begin
          stateNext = EXECUTE;
        end
      end
      EXECUTE: begin
        case (execClass)
          CLS_R, CLS_IALU, CLS_JAL: stateNext = WB;
          CLS_LOAD, CLS_STORE:      stateNext = MEM;
          default:                  stateNext = FETCH;
        endcase
      end
      MEM: begin
        if ((execClass != CLS_LOAD) && (execClass != CLS_STORE)) stateNext = FETCH;
        else if (bus.mem_ready) stateNext = (execClass == CLS_LOAD) ? WB : FETCH;
        else if (waitExpired) begin
          stateNext  = TRAP;
          timeoutSet = 1'b1;
        end else                stateNext = MEM;
      end
      WB:      stateNext = FETCH;
      TRAP:    stateNext = TRAP;
      default: stateNext = FETCH;
    endcase
  end

  // Output decode per state and class; everything is held low during reset.
  always_comb begin
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    aluSrc    = 1'b0;
    regWrite  = 1'b0;
    branchOut = 1'b0;
    jumpOut   = 1'b0;
    aluOp     = '0;
    if (reset_n) begin
      case (stateCur)
        FETCH: begin
          memRead = 1'b1;
          if (bus.mem_ready) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
          end
        end
        EXECUTE: begin
          case (execClass)
            CLS_R:    aluOp = ALUOP_W'(2'd2);
            CLS_IALU: begin
              aluOp  = ALUOP_W'(2'd3);
              aluSrc = 1'b1;
            end
            CLS_LOAD, CLS_STORE: aluSrc = 1'b1;
            CLS_BRANCH: begin
              aluOp     = ALUOP_W'(2'd1);
              branchOut = 1'b1;
            end
            CLS_JAL: begin
              jumpOut = 1'b1;
              pcWrite = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          memRead  = (execClass == CLS_LOAD);
          memWrite = (execClass == CLS_STORE);
        end
        WB: begin
          regWrite = 1'b1;
          memToReg = (execClass == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = pcWrite;
  assign bus.ir_write   = irWrite;
  assign bus.mem_read   = memRead;
  assign bus.mem_write  = memWrite;
  assign bus.mem_to_reg = memToReg;
  assign bus.alu_src    = aluSrc;
  assign bus.reg_write  = regWrite;
  assign bus.branch     = branchOut;
  assign bus.jump       = jumpOut;
  assign bus.alu_op     = aluOp;
  assign bus.illegal    = reset_n & illegalFlag;
  assign bus.timeout    = reset_n & timeoutFlag;
  assign bus.state      = stateCur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each instruction is expanded into its
// expected per-cycle trace (inputs to drive plus outputs to expect) from the
// instruction-level rules, then played against the DUT cycle by cycle.
module tb_multicycle_control_unit;

  localparam int ALUOP_W = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Output vector layout: state[15:13] pcw irw mr mw m2r asrc rw br jp aop[3:2] ill to
  localparam logic [15:0] PCW  = 16'h1000;
  localparam logic [15:0] IRW  = 16'h0800;
  localparam logic [15:0] MR   = 16'h0400;
  localparam logic [15:0] MW   = 16'h0200;
  localparam logic [15:0] M2R  = 16'h0100;
  localparam logic [15:0] ASRC = 16'h0080;
  localparam logic [15:0] RW   = 16'h0040;
  localparam logic [15:0] BR   = 16'h0020;
  localparam logic [15:0] JP   = 16'h0010;
  localparam logic [15:0] AOP0 = 16'h0000;
  localparam logic [15:0] AOP1 = 16'h0004;
  localparam logic [15:0] AOP2 = 16'h0008;
  localparam logic [15:0] AOP3 = 16'h000C;

  typedef struct {
    logic        mr;
    logic [6:0]  op;
    logic        rst;
    logic [15:0] exp;
  } step_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUOP_W(ALUOP_W)) bus ();

  multicycle_control_unit #(
    .ALUOP_W(ALUOP_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  step_t trace[$];
  logic  tIll;
  logic  tTo;
  int    compared   = 0;
  int    mismatched = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] observed();
    return {bus.state, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.alu_src, bus.reg_write, bus.branch, bus.jump,
            bus.alu_op, bus.illegal, bus.timeout};
  endfunction

  function automatic logic [15:0] ex(input logic [2:0] st, input logic [15:0] bits);
    return {st, 13'b0} | bits | {14'b0, tIll, tTo};
  endfunction

  // Opcode noise after DECODE; half the time it is STORE to expose any use of the live opcode.
  function automatic logic [6:0] garbage();
    if ($urandom_range(0, 1) == 1) return OP_STORE;
    return 7'($urandom);
  endfunction

  task automatic pushStep(input logic mr, input logic [6:0] op, input logic rst, input logic [15:0] exp);
    step_t s;
    s.mr  = mr;
    s.op  = op;
    s.rst = rst;
    s.exp = exp;
    trace.push_back(s);
  endtask

  task automatic waitPhase(input logic [2:0] st, input logic [15:0] holdBits,
                           input logic [15:0] readyBits, input int n,
                           input logic [6:0] op, input bit garb, output bit trapped);
    int w;
    w = (n > TIMEOUT) ? TIMEOUT : n;
    trapped = 1'b0;
    for (int i = 0; i < w; i++) pushStep(1'b0, garb ? garbage() : op, 1'b0, ex(st, holdBits));
    if (n >= TIMEOUT) begin
      tTo     = 1'b1;
      trapped = 1'b1;
    end else begin
      pushStep(1'b1, garb ? garbage() : op, 1'b0, ex(st, holdBits | readyBits));
    end
  endtask

  task automatic buildInstr(input logic [6:0] op, input int f, input int m, input int abortAt);
    bit trapped;
    bit isMem;
    bit isLoad;
    bit toWb;
    logic [15:0] execBits;
    trace.delete();
    tIll = 1'b0;
    tTo  = 1'b0;
    isMem = 1'b0;
    isLoad = 1'b0;
    toWb = 1'b0;
    execBits = '0;
    waitPhase(3'd0, MR, PCW | IRW, f, op, 1'b0, trapped);
    if (!trapped) begin
      pushStep(1'($urandom), op, 1'b0, ex(3'd1, '0));
      case (op)
        OP_R:      begin execBits = AOP2;            toWb = 1'b1; end
        OP_IALU:   begin execBits = AOP3 | ASRC;     toWb = 1'b1; end
        OP_LOAD:   begin execBits = AOP0 | ASRC;     isMem = 1'b1; isLoad = 1'b1; end
        OP_STORE:  begin execBits = AOP0 | ASRC;     isMem = 1'b1; end
        OP_BRANCH: begin execBits = AOP1 | BR;       end
        OP_JAL:    begin execBits = AOP0 | JP | PCW; toWb = 1'b1; end
        default:   begin tIll = 1'b1; trapped = 1'b1; end
      endcase
    end
    if (!trapped) begin
      pushStep(1'($urandom), garbage(), 1'b0, ex(3'd2, execBits));
      if (isMem) begin
        waitPhase(3'd3, isLoad ? MR : MW, '0, m, 7'b0, 1'b1, trapped);
        toWb = isLoad && !trapped;
      end
    end
    if (!trapped && toWb)
      pushStep(1'($urandom), garbage(), 1'b0, ex(3'd4, RW | (isLoad ? M2R : 16'h0)));
    if (trapped) begin
      for (int i = 0; i < 20; i++) pushStep(1'($urandom), 7'($urandom), 1'b0, ex(3'd5, '0));
      pushStep(1'($urandom), 7'($urandom), 1'b1, {3'd5, 13'b0});
    end
    if (abortAt >= 0 && abortAt < trace.size()) begin
      while (trace.size() > abortAt + 1) void'(trace.pop_back());
      trace[abortAt].rst = 1'b1;
      trace[abortAt].exp = {trace[abortAt].exp[15:13], 13'b0};
    end
  endtask

  // Enters with the clock just past a rising edge; leaves the same way.
  task automatic runTrace(input string name);
    for (int i = 0; i < trace.size(); i++) begin
      bus.opcode    = trace[i].op;
      bus.mem_ready = trace[i].mr;
      reset_n       = !trace[i].rst;
      @(negedge clk);
      checkVal($sformatf("%s#%0d", name, i), observed(), trace[i].exp);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end
  endtask

  function automatic logic [6:0] pickOp();
    case ($urandom_range(0, 7))
      0: return OP_R;
      1: return OP_IALU;
      2: return OP_LOAD;
      3: return OP_STORE;
      4: return OP_BRANCH;
      5: return OP_JAL;
      6: return OP_LOAD;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic int pickWait();
    case ($urandom_range(0, 9))
      0: return TIMEOUT - 1;
      1: return TIMEOUT;
      default: return $urandom_range(0, 4);
    endcase
  endfunction

  initial begin
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("reset_outputs", observed(), 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    buildInstr(OP_R, 0, 0, -1);          runTrace("r_type");
    buildInstr(OP_LOAD, 2, 3, -1);       runTrace("load_m3");
    buildInstr(7'b1111111, 0, 0, -1);    runTrace("illegal");
    buildInstr(OP_IALU, TIMEOUT, 0, -1); runTrace("fetch_timeout");
    buildInstr(OP_IALU, TIMEOUT - 1, 0, -1); runTrace("fetch_last_ready");
    buildInstr(OP_STORE, 1, 5, 5);       runTrace("store_abort");
    buildInstr(OP_STORE, 0, TIMEOUT, -1); runTrace("mem_timeout");
    buildInstr(OP_LOAD, 0, TIMEOUT - 1, -1); runTrace("mem_last_ready");
    buildInstr(OP_BRANCH, 3, 0, -1);     runTrace("branch");
    buildInstr(OP_JAL, 1, 0, -1);        runTrace("jal");

    for (int n = 0; n < 200; n++) begin
      int ab;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : -1;
      buildInstr(pickOp(), pickWait(), pickWait(), ab);
      runTrace($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
